mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage data-memory access unit for the 64-bit pipelined core. Sits directly downstream of the EX/MEM pipeline register. It consumes the memory-control bits, ALU address, store data and funct3 held there, and runs a request/acknowledge transaction on the data bus. It stalls the pipeline until the access completes, then hands aligned, extended load data to the MEM/WB register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles without `dbus_ack` before a bus fault (used only with `MEM_TIMEOUT_EN`).

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  EX/MEM holds a real instruction (not a bubble).
- mem_m  in  3  memory control from EX/MEM; [1]=mem_read, [0]=mem_write, [2] ignored.
- mem_funct3  in  3  inst[14:12]: size/sign code.
- mem_addr  in  64  byte address (EX/MEM ALU result).
- mem_wdata  in  64  store data (EX/MEM rs2 data).
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- load_data  out  64  aligned, extended load result.
- load_valid  out  1  one-cycle pulse: `load_data` updated.
- misalign_exc  out  1  one-cycle pulse: misaligned access.
- fault_exc  out  1  one-cycle pulse: illegal encoding or bus timeout.
- dbus_req  out  1  bus request, held until ack.
- dbus_we  out  1  1=write.
- dbus_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0}).
- dbus_wdata  out  64  lane-shifted store data.
- dbus_wstrb  out  8  byte enables.
- dbus_ack  in  1  transfer complete this cycle.
- dbus_rdata  in  64  read data, valid with ack.

## Operation
- States: IDLE, REQ, DONE.
- In IDLE, an access is `mem_valid & (mem_read | mem_write)`.
- Size decode from funct3[1:0]: 00 byte, 01 half, 10 word, 11 dword.
  - funct3[2]=1 on a load means zero-extend.
- Illegal encodings:
  - load funct3=111;
  - store funct3[2]=1;
  - read and write both set.
- Misaligned: address low bits are not zero for the size (half addr[0]; word addr[1:0]; dword addr[2:0]).
- IDLE transitions:
  - Legal, aligned access: latch bus address, we, shifted wdata and strobes. Go to REQ.
  - Illegal access: go to DONE, flag fault. No bus activity.
  - Misaligned access: go to DONE, flag misalign. No bus activity.
  - Otherwise: stay in IDLE.
- REQ:
  - `dbus_req`=1 with latched, stable fields.
  - On `dbus_ack`: go to DONE; for loads, capture `dbus_rdata >> (addr[2:0]*8)`, then sign- or zero-extend from the size.
- DONE: pulse `load_valid` (loads only) or the flagged exception for one cycle. Always return to IDLE.
- Store lanes:
  - `dbus_wdata` = `mem_wdata << (addr[2:0]*8)`.
  - `dbus_wstrb` = size mask (0x01/0x03/0x0F/0xFF) `<< addr[2:0]`.
- `stall` = (IDLE & access) | REQ. It is 0 in DONE, so EX/MEM advances at the end of DONE; DONE never restarts the same access.
- On fault, `load_data` is written 0. `load_data` holds its value between updates.
- `dbus_ack` is ignored outside REQ.

## Timing
- Reset (sync rst=1 at an edge): state IDLE; all outputs 0, including `dbus_req`, `dbus_wstrb`, `load_data` and `stall`.
- Reset mid-REQ: `dbus_req` drops after that edge; the access is abandoned.
- Bus outputs are registered. `stall` is combinational from state and inputs.
- Zero-wait ack gives 3 cycles total:
  - cycle 0: IDLE, stall=1;
  - cycle 1: REQ, req=1, ack=1;
  - cycle 2: DONE, load_valid=1, stall=0.
- Each wait cycle of ack adds one REQ cycle.
- Exception path is 2 cycles: IDLE (stall=1), then DONE (exc pulse).
- Simultaneous ack and timeout limit in the same cycle: the ack wins; no fault.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider REQ-cycle counter, cleared on entry to REQ.
  - After TIMEOUT_CYCLES REQ cycles without ack: drop `dbus_req`, go to DONE, pulse `fault_exc`, set `load_data`=0.
- Undefined: REQ waits indefinitely; `fault_exc` is driven only by illegal encodings.

## Test plan
- LD addr 0x1000, ack in first REQ cycle, rdata 0x1122334455667788 -> req for 1 cycle, stall 2 cycles, load_valid with `load_data`=0x1122334455667788.
- LB at 0x1003 with rdata 0x0000000085000000 -> 0xFFFFFFFFFFFFFF85; LBU -> 0x85.
- SH addr 0x1006, wdata 0xABCD -> dbus_addr 0x1000, we=1, wstrb 0xC0, wdata[63:48]=0xABCD.
- LW addr 0x1002 -> no dbus_req, misalign_exc pulse in cycle 2, stall only in cycle 1.
- `MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=4, ack never arrives -> req high exactly 4 cycles, then fault_exc pulse and `load_data`=0. Repeat with ack in the 4th cycle -> normal completion, no fault.
- rst asserted during REQ with ack withheld -> req=0, stall=0 after the edge; a later ack causes no load_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory access unit for the 64-bit pipelined core. Takes the
// memory-control bits, ALU address, store data and funct3 from the EX/MEM
// register, runs one request/acknowledge transaction on the data bus, stalls
// the pipeline until it completes, and returns aligned, extended load data.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> a REQ that sees no dbus_ack for TIMEOUT_CYCLES cycles is
//                abandoned with a fault_exc pulse and load_data cleared.
//   undefined -> REQ waits for dbus_ack indefinitely.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_valid           EX/MEM holds a real instruction
//   mem_m[2:0]          [1]=mem_read, [0]=mem_write, [2] unused here
//   mem_funct3[2:0]     size/sign code (inst[14:12])
//   mem_addr[63:0]      byte address
//   mem_wdata[63:0]     store data
//   stall               hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   load_data[63:0]     aligned, extended load result (held between updates)
//   load_valid          one-cycle pulse: load_data updated
//   misalign_exc        one-cycle pulse: misaligned access
//   fault_exc           one-cycle pulse: illegal encoding or bus timeout
//   dbus_req/we/addr/wdata/wstrb  registered data-bus request fields
//   dbus_ack, dbus_rdata          bus completion and read data
//   state_dbg[1:0]      current FSM state (0=IDLE, 1=REQ, 2=DONE)
//
// Bus handshake: dbus_req rises the cycle after an access is accepted and
// stays high with stable we/addr/wdata/wstrb until the first cycle in which
// dbus_ack is sampled high; that cycle completes the transfer and dbus_rdata
// is taken in the same cycle. dbus_ack outside REQ is ignored.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [2:0]  mem_m,
   input  logic [2:0]  mem_funct3,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic        stall,
   output logic [63:0] load_data,
   output logic        load_valid,
   output logic        misalign_exc,
   output logic        fault_exc,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [63:0] dbus_addr,
   output logic [63:0] dbus_wdata,
   output logic [7:0]  dbus_wstrb,
   input  logic        dbus_ack,
   input  logic [63:0] dbus_rdata,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;

`ifdef MEM_TIMEOUT_EN
   localparam logic TIMEOUT_ON = 1'b1;
`else
   localparam logic TIMEOUT_ON = 1'b0;
`endif

   // REQ-cycle counter: at least 8 bits, wide enough to hold TIMEOUT_CYCLES.
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] req_cnt;

   // Fields captured when a bus access is launched, used to align the reply.
   logic [2:0] lat_funct3;
   logic [2:0] lat_off;
   logic       lat_load;

   // ---------------------------------------------------------------- decode
   logic        mem_read;
   logic        mem_write;
   logic        access;
   logic        illegal;
   logic        misaligned;
   logic [7:0]  size_mask;
   logic [5:0]  shamt;
   logic [63:0] wdata_sh;
   logic [7:0]  wstrb_sh;
   logic        timeout_hit;
   logic        unused_m2;

   assign mem_read  = mem_m[1];
   assign mem_write = mem_m[0];
   assign access    = mem_valid & (mem_read | mem_write);
   assign unused_m2 = mem_m[2];

   assign illegal = (mem_read & mem_write)
                  | (mem_read & (mem_funct3 == 3'b111))
                  | (mem_write & mem_funct3[2]);

   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (mem_funct3[1:0])
         2'b00: begin misaligned = 1'b0;             size_mask = 8'h01; end
         2'b01: begin misaligned = mem_addr[0];      size_mask = 8'h03; end
         2'b10: begin misaligned = |mem_addr[1:0];   size_mask = 8'h0F; end
         default: begin misaligned = |mem_addr[2:0]; size_mask = 8'hFF; end
      endcase
   end

   assign shamt    = {mem_addr[2:0], 3'b000};
   assign wdata_sh = mem_wdata << shamt;
   assign wstrb_sh = size_mask << mem_addr[2:0];

   // The ack check has priority over this in the FSM, so an ack arriving on
   // the limit cycle completes normally.
   assign timeout_hit = TIMEOUT_ON & (state == S_REQ) & (req_cnt == CNT_LIMIT);

   // ------------------------------------------------------ load alignment
   logic [63:0] rdata_sh;
   logic [63:0] rdata_ext;
   logic        sign_ext;

   assign rdata_sh = dbus_rdata >> {lat_off, 3'b000};
   assign sign_ext = ~lat_funct3[2];

   always_comb begin
      rdata_ext = rdata_sh;
      case (lat_funct3[1:0])
         2'b00:   rdata_ext = {{56{sign_ext & rdata_sh[7]}},  rdata_sh[7:0]};
         2'b01:   rdata_ext = {{48{sign_ext & rdata_sh[15]}}, rdata_sh[15:0]};
         2'b10:   rdata_ext = {{32{sign_ext & rdata_sh[31]}}, rdata_sh[31:0]};
         default: rdata_ext = rdata_sh;
      endcase
   end

   // --------------------------------------------------------------- outputs
   // stall drops in DONE so EX/MEM advances at the end of that cycle; DONE
   // always returns to IDLE, so the same access is never started twice.
   assign stall     = ((state == S_IDLE) & access) | (state == S_REQ);
   assign state_dbg = state;

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         req_cnt      <= '0;
         lat_funct3   <= 3'b000;
         lat_off      <= 3'b000;
         lat_load     <= 1'b0;
         load_data    <= 64'd0;
         load_valid   <= 1'b0;
         misalign_exc <= 1'b0;
         fault_exc    <= 1'b0;
         dbus_req     <= 1'b0;
         dbus_we      <= 1'b0;
         dbus_addr    <= 64'd0;
         dbus_wdata   <= 64'd0;
         dbus_wstrb   <= 8'h00;
      end else begin
         load_valid   <= 1'b0;
         misalign_exc <= 1'b0;
         fault_exc    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (access) begin
                  if (illegal) begin
                     state     <= S_DONE;
                     fault_exc <= 1'b1;
                     load_data <= 64'd0;
                  end else if (misaligned) begin
                     state        <= S_DONE;
                     misalign_exc <= 1'b1;
                  end else begin
                     state      <= S_REQ;
                     req_cnt    <= '0;
                     dbus_req   <= 1'b1;
                     dbus_we    <= mem_write;
                     dbus_addr  <= {mem_addr[63:3], 3'b000};
                     dbus_wdata <= mem_write ? wdata_sh : 64'd0;
                     dbus_wstrb <= mem_write ? wstrb_sh : 8'h00;
                     lat_funct3 <= mem_funct3;
                     lat_off    <= mem_addr[2:0];
                     lat_load   <= mem_read;
                  end
               end
            end
            S_REQ: begin
               if (dbus_ack) begin
                  state    <= S_DONE;
                  dbus_req <= 1'b0;
                  if (lat_load) begin
                     load_data  <= rdata_ext;
                     load_valid <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state     <= S_DONE;
                  dbus_req  <= 1'b0;
                  fault_exc <= 1'b1;
                  load_data <= 64'd0;
               end else begin
                  req_cnt <= req_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
